// File: rtl/filter_pkg.sv
// Definitions shared by the filter datapath and its sample feeder:
// sample width, feeder FSM states and FIFO pointer sizing.
package filter_pkg;

  localparam int DW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } feeder_state_e;

  // Address bits needed to index a FIFO of the given depth (depth >= 2).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO; the head entry is read straight out of the
// storage registers, so a pop returns it in the same cycle.
module sample_fifo
  import filter_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = ptr_w(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra lap bit: equal addresses with different laps
  // means full, identical pointers means empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; empty/level gate every read,
  // so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/filter_sample_feeder.sv
// Rate-controlled sample source for the filter's Xn input: buffers upstream
// samples and emits one every RATE_DIV clocks, zero-stuffing on underrun.
module filter_sample_feeder
  import filter_pkg::*;
#(
  parameter int DW       = filter_pkg::DW,
  parameter int DEPTH    = 8,
  parameter int RATE_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [DW-1:0]          wr_data,
  output logic                   wr_ready,
  input  logic                   run,
  output logic [DW-1:0]          Xn,
  output logic                   x_valid,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level
);

  localparam logic [15:0] LAST = 16'(RATE_DIV - 1);

  feeder_state_e state, state_next;
  logic [15:0]   count;
  logic          tick;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_head;

  assign wr_ready = !fifo_full;

  sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (tick),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: defaults first so no path through this block leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    tick       = 1'b0;
    unique case (state)
      IDLE: if (run) state_next = RUN;
      RUN: begin
        tick = (count == LAST);
        if (!run) state_next = IDLE;
      end
    endcase
  end

  // Counter sits at 0 outside RUN so every return to RUN restarts the period.
  always_ff @(posedge clk) begin
    if (reset || state != RUN) count <= '0;
    else if (tick)             count <= '0;
    else                       count <= count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Xn       <= '0;
      x_valid  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      x_valid <= tick;
      if (tick) begin
        Xn <= fifo_empty ? '0 : fifo_head;
        if (fifo_empty) underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_filter_sample_feeder.sv
// Scoreboard bench for filter_sample_feeder: a paced instance (RATE_DIV=4)
// and a full-rate instance (RATE_DIV=1) share clock and reset.
module tb_filter_sample_feeder;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int RDIV  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          wr_valid, wr_valid_f;
  logic [DW-1:0] wr_data, wr_data_f;
  logic          run, run_f;
  logic          wr_ready, wr_ready_f;
  logic [DW-1:0] xn, xn_f;
  logic          x_valid, x_valid_f;
  logic          underrun, underrun_f;
  logic [LW-1:0] level, level_f;

  filter_sample_feeder #(.DW(DW), .DEPTH(DEPTH), .RATE_DIV(RDIV)) u_dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .run(run), .Xn(xn), .x_valid(x_valid),
    .underrun(underrun), .level(level)
  );

  filter_sample_feeder #(.DW(DW), .DEPTH(DEPTH), .RATE_DIV(1)) u_fast (
    .clk(clk), .reset(reset), .wr_valid(wr_valid_f), .wr_data(wr_data_f),
    .wr_ready(wr_ready_f), .run(run_f), .Xn(xn_f), .x_valid(x_valid_f),
    .underrun(underrun_f), .level(level_f)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_qf[$];
  int            last_strobe = -1;
  bit            check_gap   = 1'b0;
  logic [DW-1:0] last_exp    = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Scoreboard side: every strobe consumes the oldest expected sample.
  always @(negedge clk) begin
    if (!reset && x_valid) begin
      if (check_gap && last_strobe >= 0) check("strobe_gap", 32'(cyc - last_strobe), 32'(RDIV));
      last_strobe = cyc;
      if (exp_q.size() == 0) check("strobe_with_empty_scoreboard", 32'(x_valid), 32'd0);
      else begin
        last_exp = exp_q.pop_front();
        check("xn", 32'(xn), 32'(last_exp));
      end
    end
    if (!reset && x_valid_f) begin
      if (exp_qf.size() == 0) check("fast_strobe_with_empty_scoreboard", 32'(x_valid_f), 32'd0);
      else check("fast_xn", 32'(xn_f), 32'(exp_qf.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input int d);
    wr_valid = 1'b1;
    wr_data  = DW'(d);
    step();
    wr_valid = 1'b0;
    exp_q.push_back(DW'(d));
  endtask

  task automatic push_fast(input int d);
    wr_valid_f = 1'b1;
    wr_data_f  = DW'(d);
    step();
    wr_valid_f = 1'b0;
    exp_qf.push_back(DW'(d));
  endtask

  task automatic wait_q(input int target, input int budget);
    int n = 0;
    while (exp_q.size() > target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() > target) check("scoreboard_timeout", 32'(exp_q.size()), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c_run;
    int mlvl;
    logic [DW-1:0] hold;

    // Reset dominates active writes and run.
    reset = 1'b1; wr_valid = 1'b1; wr_data = 16'hAAAA; run = 1'b1;
    wr_valid_f = 1'b1; wr_data_f = 16'h5555; run_f = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_level", 32'(level), 32'd0);
    check("reset_xn", 32'(xn), 32'd0);
    check("reset_x_valid", 32'(x_valid), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);
    check("reset_wr_ready", 32'(wr_ready), 32'd1);
    check("reset_fast_level", 32'(level_f), 32'd0);
    #1;
    reset = 1'b0; wr_valid = 1'b0; run = 1'b0; wr_valid_f = 1'b0; run_f = 1'b0;
    step();
    @(negedge clk);
    check("post_reset_level", 32'(level), 32'd0);
    check("post_reset_x_valid", 32'(x_valid), 32'd0);
    step();

    // Paced stream followed by two zero-stuffed strobes.
    for (int i = 1; i <= 5; i++) push0(i);
    @(negedge clk);
    check("stream_level", 32'(level), 32'd5);
    #1;
    exp_q.push_back('0);
    exp_q.push_back('0);
    run = 1'b1;
    c_run = cyc + 1;
    last_strobe = -1;
    check_gap = 1'b1;
    wait_q(6, 40);
    check("first_strobe_latency", 32'(last_strobe - c_run), 32'(RDIV));
    wait_q(2, 40);
    check("underrun_clear_while_fed", 32'(underrun), 32'd0);
    wait_q(0, 40);
    check("underrun_set", 32'(underrun), 32'd1);
    run = 1'b0;
    check_gap = 1'b0;
    repeat (3) step();
    check("underrun_sticky", 32'(underrun), 32'd1);

    // Fill past capacity while idle.
    mlvl = 0;
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(10 + i);
      @(negedge clk);
      check("full_wr_ready", 32'(wr_ready), 32'(mlvl < DEPTH));
      if (mlvl < DEPTH) begin
        exp_q.push_back(DW'(10 + i));
        mlvl++;
      end
      step();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_wr_ready_low", 32'(wr_ready), 32'd0);
    #1;
    run = 1'b1;
    last_strobe = -1;
    check_gap = 1'b1;
    wait_q(0, 80);
    run = 1'b0;
    check_gap = 1'b0;
    step();
    check("full_drained_level", 32'(level), 32'd0);

    // Full-rate instance: push and pop every cycle at level 3.
    for (int i = 0; i < 3; i++) push_fast(100 + i);
    run_f = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      wr_valid_f = 1'b1;
      wr_data_f  = DW'(103 + i);
      exp_qf.push_back(DW'(103 + i));
      @(negedge clk);
      check("fast_level_steady", 32'(level_f), 32'd3);
      step();
    end
    wr_valid_f = 1'b0;
    repeat (2) step();
    run_f = 1'b0;
    repeat (4) step();
    check("fast_drain", 32'(exp_qf.size()), 32'd0);
    check("fast_level_empty", 32'(level_f), 32'd0);
    check("fast_no_underrun", 32'(underrun_f), 32'd0);

    // Drop run mid-stream, resume, then reset with data still queued.
    for (int i = 20; i < 28; i++) push0(i);
    run = 1'b1;
    last_strobe = -1;
    check_gap = 1'b1;
    wait_q(6, 40);
    run = 1'b0;
    check_gap = 1'b0;
    hold = last_exp;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_no_strobe", 32'(x_valid), 32'd0);
      check("idle_xn_held", 32'(xn), 32'(hold));
    end
    #1;
    run = 1'b1;
    c_run = cyc + 1;
    last_strobe = -1;
    check_gap = 1'b1;
    wait_q(5, 40);
    check("resume_latency", 32'(last_strobe - c_run), 32'(RDIV));
    wait_q(4, 40);
    check("pre_reset_level", 32'(level), 32'd4);
    reset = 1'b1;
    run = 1'b0;
    check_gap = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_level", 32'(level), 32'd0);
    check("midreset_xn", 32'(xn), 32'd0);
    check("midreset_x_valid", 32'(x_valid), 32'd0);
    check("midreset_underrun", 32'(underrun), 32'd0);
    check("midreset_wr_ready", 32'(wr_ready), 32'd1);
    exp_q.delete();
    #1;
    reset = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
